// File: rtl/fb_write_arbiter.sv
// Frame buffer write-port arbiter: forwards APB pixel writes at a fixed 1-cycle
// latency and spends the remaining cycles on a rectangle-fill engine.
module fb_write_arbiter #(
    parameter int ROW_W  = 6,
    parameter int COL_W  = 9,
    parameter int DATA_W = 16
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   apb_wr,
    input  logic [DATA_W-1:0]      apb_data,
    input  logic [ROW_W+COL_W-1:0] apb_waddr,
    input  logic                   fill_start,
    input  logic                   fill_abort,
    input  logic [DATA_W-1:0]      fill_color,
    input  logic [ROW_W-1:0]       fill_row0,
    input  logic [ROW_W:0]         fill_rows,
    input  logic [COL_W-1:0]       fill_col0,
    input  logic [COL_W:0]         fill_cols,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic [15:0]            fill_stall_cnt,
    output logic                   mem_wr,
    output logic [DATA_W-1:0]      mem_data,
    output logic [ROW_W+COL_W-1:0] mem_waddr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic [DATA_W-1:0]        r_color;
    logic [ROW_W-1:0]         r_row0;
    logic [ROW_W:0]           r_rows;
    logic [COL_W-1:0]         r_col0;
    logic [COL_W:0]           r_cols;
    logic [ROW_W:0]           r_row_ctr;
    logic [COL_W:0]           r_col_ctr;
    logic [15:0]              r_stall_cnt;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_mem_wr;
    logic [DATA_W-1:0]        r_mem_data;
    logic [ROW_W+COL_W-1:0]   r_mem_waddr;

    logic                     w_start_ok;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_fill_issue;
    logic                     w_stall;
    logic [ROW_W-1:0]         w_fill_row;
    logic [COL_W-1:0]         w_fill_col;

    assign w_start_ok = fill_start && (fill_rows != '0) && (fill_cols != '0);
    assign w_col_last = (r_col_ctr == r_cols - 1'b1);
    assign w_row_last = (r_row_ctr == r_rows - 1'b1);

    // Abort wins over both the fill write and the stall count in the same cycle.
    assign w_fill_issue = (r_state == FILL) && !apb_wr && !fill_abort;
    assign w_stall      = (r_state == FILL) &&  apb_wr && !fill_abort;

    // Address sums deliberately truncate so rectangles wrap around the buffer edge.
    assign w_fill_row = r_row0 + r_row_ctr[ROW_W-1:0];
    assign w_fill_col = r_col0 + r_col_ctr[COL_W-1:0];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (fill_start) begin
                    w_next = w_start_ok ? FILL : DONE;
                end
            end
            FILL: begin
                if (fill_abort) begin
                    w_next = DONE;
                end else if (w_fill_issue && w_col_last && w_row_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_color     <= '0;
            r_row0      <= '0;
            r_rows      <= '0;
            r_col0      <= '0;
            r_cols      <= '0;
            r_row_ctr   <= '0;
            r_col_ctr   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && w_start_ok) begin
                r_color     <= fill_color;
                r_row0      <= fill_row0;
                r_rows      <= fill_rows;
                r_col0      <= fill_col0;
                r_cols      <= fill_cols;
                r_row_ctr   <= '0;
                r_col_ctr   <= '0;
                r_stall_cnt <= '0;
            end else begin
                if (w_fill_issue) begin
                    if (w_col_last) begin
                        r_col_ctr <= '0;
                        r_row_ctr <= r_row_ctr + 1'b1;
                    end else begin
                        r_col_ctr <= r_col_ctr + 1'b1;
                    end
                end
                if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                    r_stall_cnt <= r_stall_cnt + 16'd1;
                end
            end
        end
    end

    // Single output register: APB has priority, so only one source lands per cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_mem_wr    <= 1'b0;
            r_mem_data  <= '0;
            r_mem_waddr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mem_wr <= apb_wr || w_fill_issue;
            if (apb_wr) begin
                r_mem_data  <= apb_data;
                r_mem_waddr <= apb_waddr;
            end else if (w_fill_issue) begin
                r_mem_data  <= r_color;
                r_mem_waddr <= {w_fill_row, w_fill_col};
            end
            r_busy <= (w_next == FILL);
            r_done <= (r_state == DONE);
        end
    end

    assign fill_busy      = r_busy;
    assign fill_done      = r_done;
    assign fill_stall_cnt = r_stall_cnt;
    assign mem_wr         = r_mem_wr;
    assign mem_data       = r_mem_data;
    assign mem_waddr      = r_mem_waddr;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_fb_write_arbiter;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 9;
    localparam int DATA_W = 16;
    localparam int AW     = ROW_W + COL_W;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic              apb_wr = 1'b0;
    logic [DATA_W-1:0] apb_data = '0;
    logic [AW-1:0]     apb_waddr = '0;
    logic              fill_start = 1'b0;
    logic              fill_abort = 1'b0;
    logic [DATA_W-1:0] fill_color = '0;
    logic [ROW_W-1:0]  fill_row0 = '0;
    logic [ROW_W:0]    fill_rows = '0;
    logic [COL_W-1:0]  fill_col0 = '0;
    logic [COL_W:0]    fill_cols = '0;
    logic              fill_busy;
    logic              fill_done;
    logic [15:0]       fill_stall_cnt;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_data;
    logic [AW-1:0]     mem_waddr;

    fb_write_arbiter #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) dut (
        .pclk(pclk), .presetn(presetn),
        .apb_wr(apb_wr), .apb_data(apb_data), .apb_waddr(apb_waddr),
        .fill_start(fill_start), .fill_abort(fill_abort), .fill_color(fill_color),
        .fill_row0(fill_row0), .fill_rows(fill_rows),
        .fill_col0(fill_col0), .fill_cols(fill_cols),
        .fill_busy(fill_busy), .fill_done(fill_done), .fill_stall_cnt(fill_stall_cnt),
        .mem_wr(mem_wr), .mem_data(mem_data), .mem_waddr(mem_waddr)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a fill is just the ordered list of addresses still to paint.
    logic [AW-1:0]     m_q[$];
    bit                m_active;
    bit                m_in_done;
    logic [DATA_W-1:0] m_color;
    logic [15:0]       m_stall;
    bit                e_wr;
    logic [DATA_W-1:0] e_data;
    logic [AW-1:0]     e_addr;
    bit                e_busy;
    bit                e_done;

    logic [AW-1:0]     obs_a[$];
    logic [DATA_W-1:0] obs_d[$];
    int                obs_c[$];
    int                done_cyc;

    typedef struct {
        bit                wr;
        logic [DATA_W-1:0] d;
        logic [AW-1:0]     a;
        bit                ewr;
        logic [DATA_W-1:0] ed;
        logic [AW-1:0]     ea;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_in_done = 0;
        m_stall   = '0;
        m_q.delete();
    endtask

    task automatic model_cycle();
        e_done    = m_in_done;
        m_in_done = 0;
        e_wr      = 0;
        if (apb_wr) begin
            e_wr   = 1;
            e_data = apb_data;
            e_addr = apb_waddr;
        end
        if (m_active) begin
            if (fill_abort) begin
                m_active  = 0;
                m_q.delete();
                m_in_done = 1;
            end else if (apb_wr) begin
                if (m_stall != 16'hFFFF) m_stall++;
            end else begin
                e_wr   = 1;
                e_data = m_color;
                e_addr = m_q.pop_front();
                if (m_q.size() == 0) begin
                    m_active  = 0;
                    m_in_done = 1;
                end
            end
        end else if (!e_done && fill_start) begin
            if (fill_rows != 0 && fill_cols != 0) begin
                m_color = fill_color;
                m_stall = '0;
                m_q.delete();
                for (int r = 0; r < int'(fill_rows); r++)
                    for (int c = 0; c < int'(fill_cols); c++)
                        m_q.push_back({fill_row0 + 6'(r), fill_col0 + 9'(c)});
                m_active = 1;
            end else begin
                m_in_done = 1;
            end
        end
        e_busy = m_active;
    endtask

    task automatic step();
        model_cycle();
        @(posedge pclk);
        #1;
        cyc++;
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        if (e_wr) begin
            chk("mem_data", 32'(mem_data), 32'(e_data));
            chk("mem_waddr", 32'(mem_waddr), 32'(e_addr));
        end
        chk("fill_busy", 32'(fill_busy), 32'(e_busy));
        chk("fill_done", 32'(fill_done), 32'(e_done));
        chk("stall_cnt", 32'(fill_stall_cnt), 32'(m_stall));
        if (mem_wr) begin
            obs_a.push_back(mem_waddr);
            obs_d.push_back(mem_data);
            obs_c.push_back(cyc);
        end
        if (fill_done) done_cyc = cyc;
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_d.delete();
        obs_c.delete();
        done_cyc = -1;
    endtask

    task automatic set_fill(input int row0, input int rows, input int col0, input int cols,
                            input logic [DATA_W-1:0] color);
        fill_row0  = 6'(row0);
        fill_rows  = 7'(rows);
        fill_col0  = 9'(col0);
        fill_cols  = 10'(cols);
        fill_color = color;
    endtask

    task automatic pulse_start();
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
    endtask

    vec_t vecs[5];
    int   exp_r[8];
    int   exp_c[8];
    int   c0;
    int   fw;
    int   nfill;
    bit   done_seen;

    initial begin
        vecs[0] = '{1'b1, 16'hF800, 15'h0041, 1'b1, 16'hF800, 15'h0041};
        vecs[1] = '{1'b1, 16'h001F, 15'h7FFF, 1'b1, 16'h001F, 15'h7FFF};
        vecs[2] = '{1'b0, 16'h5555, 15'h1111, 1'b0, 16'h0000, 15'h0000};
        vecs[3] = '{1'b1, 16'h1234, 15'h2A5A, 1'b1, 16'h1234, 15'h2A5A};
        vecs[4] = '{1'b0, 16'h0000, 15'h0000, 1'b0, 16'h0000, 15'h0000};
        model_reset();
        clear_obs();

        // Reset state
        @(posedge pclk);
        #1;
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_busy", 32'(fill_busy), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        chk("rst_stall", 32'(fill_stall_cnt), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_addr", 32'(mem_waddr), 32'd0);
        presetn = 1'b1;
        step();

        // APB-only vector table
        foreach (vecs[i]) begin
            apb_wr    = vecs[i].wr;
            apb_data  = vecs[i].d;
            apb_waddr = vecs[i].a;
            step();
            chk("tbl_wr", 32'(mem_wr), 32'(vecs[i].ewr));
            if (vecs[i].ewr) begin
                chk("tbl_data", 32'(mem_data), 32'(vecs[i].ed));
                chk("tbl_addr", 32'(mem_waddr), 32'(vecs[i].ea));
            end
        end
        apb_wr = 1'b0;

        // Basic fill: 2x3 at {2,10}
        exp_r = '{2, 2, 2, 3, 3, 3, 0, 0};
        exp_c = '{10, 11, 12, 10, 11, 12, 0, 0};
        clear_obs();
        set_fill(2, 2, 10, 3, 16'h07E0);
        c0 = cyc;
        pulse_start();
        for (int k = 0; k < 10; k++) step();
        chk("basic_nwr", 32'(obs_a.size()), 32'd6);
        for (int i = 0; i < 6 && i < obs_a.size(); i++) begin
            chk("basic_addr", 32'(obs_a[i]), 32'({6'(exp_r[i]), 9'(exp_c[i])}));
            chk("basic_data", 32'(obs_d[i]), 32'h07E0);
            chk("basic_cyc", 32'(obs_c[i]), 32'(c0 + 2 + i));
        end
        chk("basic_done_cyc", 32'(done_cyc), 32'(c0 + 8));
        chk("basic_busy_after", 32'(fill_busy), 32'd0);
        chk("basic_stall", 32'(fill_stall_cnt), 32'd0);

        // Contention: APB on fill cycles 2 and 3
        clear_obs();
        c0 = cyc;
        pulse_start();
        step();
        apb_wr = 1'b1; apb_data = 16'hAAAA; apb_waddr = 15'h0123;
        step();
        apb_data = 16'hBBBB; apb_waddr = 15'h0456;
        step();
        apb_wr = 1'b0;
        for (int k = 0; k < 10; k++) step();
        nfill = 0;
        for (int i = 0; i < obs_d.size(); i++)
            if (obs_d[i] == 16'h07E0) begin
                if (nfill < 6)
                    chk("cont_addr", 32'(obs_a[i]), 32'({6'(exp_r[nfill]), 9'(exp_c[nfill])}));
                nfill++;
            end
        chk("cont_nfill", 32'(nfill), 32'd6);
        chk("cont_nwr", 32'(obs_a.size()), 32'd8);
        chk("cont_done_cyc", 32'(done_cyc), 32'(c0 + 10));
        chk("cont_stall", 32'(fill_stall_cnt), 32'd2);

        // Wrap on both axes
        exp_r = '{63, 63, 63, 63, 0, 0, 0, 0};
        exp_c = '{510, 511, 0, 1, 510, 511, 0, 1};
        clear_obs();
        set_fill(63, 2, 510, 4, 16'h1F1F);
        pulse_start();
        for (int k = 0; k < 12; k++) step();
        chk("wrap_nwr", 32'(obs_a.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs_a.size(); i++)
            chk("wrap_addr", 32'(obs_a[i]), 32'({6'(exp_r[i]), 9'(exp_c[i])}));

        // Zero-size fill
        clear_obs();
        set_fill(5, 5, 5, 0, 16'hFFFF);
        c0 = cyc;
        pulse_start();
        for (int k = 0; k < 5; k++) step();
        chk("zero_nwr", 32'(obs_a.size()), 32'd0);
        chk("zero_done_cyc", 32'(done_cyc), 32'(c0 + 2));

        // Abort at write #100 of a 64x512 fill, with an ignored restart attempt
        clear_obs();
        set_fill(0, 64, 0, 512, 16'hC0DE);
        pulse_start();
        fw = 0;
        for (int k = 0; k < 400 && fw < 100; k++) begin
            if (k == 50) begin
                set_fill(9, 1, 9, 1, 16'h0BAD);
                fill_start = 1'b1;
            end
            step();
            fill_start = 1'b0;
            if (mem_wr) fw++;
        end
        chk("abort_reach100", 32'(fw), 32'd100);
        fill_abort = 1'b1;
        step();
        fill_abort = 1'b0;
        if (mem_wr) fw++;
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (mem_wr) fw++;
            if (fill_done) done_seen = 1;
        end
        chk("abort_nwr", 32'(fw), 32'd100);
        chk("abort_done", 32'(done_seen), 32'd1);
        chk("abort_busy", 32'(fill_busy), 32'd0);

        // Restart after DONE
        clear_obs();
        set_fill(2, 2, 10, 3, 16'h07E0);
        pulse_start();
        for (int k = 0; k < 10; k++) step();
        chk("restart_nwr", 32'(obs_a.size()), 32'd6);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            apb_wr     = ($urandom_range(0, 9) < 3);
            apb_data   = 16'($urandom);
            apb_waddr  = 15'($urandom);
            fill_abort = ($urandom_range(0, 49) == 0);
            fill_start = ($urandom_range(0, 14) == 0);
            set_fill($urandom_range(0, 63), $urandom_range(0, 4),
                     ($urandom_range(0, 1) != 0) ? $urandom_range(505, 511) : $urandom_range(0, 511),
                     $urandom_range(0, 6), 16'($urandom));
            step();
        end
        apb_wr = 1'b0; fill_abort = 1'b0; fill_start = 1'b0;
        for (int k = 0; k < 40; k++) step();

        // Reset asserted mid-fill
        set_fill(0, 64, 0, 512, 16'h7777);
        pulse_start();
        for (int k = 0; k < 5; k++) step();
        apb_wr = 1'b1; apb_data = 16'h9999; apb_waddr = 15'h0777;
        step();
        apb_wr = 1'b0;
        step();
        chk("prerst_busy", 32'(fill_busy), 32'd1);
        #3;
        presetn = 1'b0;
        #1;
        chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("midrst_busy", 32'(fill_busy), 32'd0);
        chk("midrst_done", 32'(fill_done), 32'd0);
        chk("midrst_stall", 32'(fill_stall_cnt), 32'd0);
        chk("midrst_data", 32'(mem_data), 32'd0);
        chk("midrst_addr", 32'(mem_waddr), 32'd0);
        model_reset();
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (fill_done) done_seen = 1;
        end
        chk("postrst_no_done", 32'(done_seen), 32'd0);
        apb_wr = 1'b1; apb_data = 16'h4321; apb_waddr = 15'h0ABC;
        step();
        apb_wr = 1'b0;
        chk("postrst_apb_wr", 32'(mem_wr), 32'd1);
        chk("postrst_apb_data", 32'(mem_data), 32'h4321);
        chk("postrst_apb_addr", 32'(mem_waddr), 32'h0ABC);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Sole owner of the frame buffer write port.
- Merges two write sources:
  - APB pass-through writes from the control/status register block. These have no back-pressure and must never be dropped or delayed beyond a fixed latency.
  - A hardware rectangle-fill engine, started by software, that paints a row/column region with one RGB565 colour.
- Fill writes only use cycles in which no APB write is present.
- Sits between the APB register block and the frame buffer RAM write port.

Parameters:
- ROW_W, 6, row index width (64 rows).
- COL_W, 9, column index width (512 columns).
- DATA_W, 16, pixel width (RGB565).

Ports:
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- apb_wr  in  1  write strobe from the APB register block, single-cycle per word
- apb_data  in  DATA_W  APB pixel data
- apb_waddr  in  ROW_W+COL_W  APB address, {row,col}
- fill_start  in  1  single-cycle pulse; starts a fill
- fill_abort  in  1  single-cycle pulse; terminates an active fill
- fill_color  in  DATA_W  fill pixel value, sampled at start
- fill_row0  in  ROW_W  first row, sampled at start
- fill_rows  in  ROW_W+1  row count (0..64), sampled at start
- fill_col0  in  COL_W  first column, sampled at start
- fill_cols  in  COL_W+1  column count (0..512), sampled at start
- fill_busy  out  1  high while the engine is in FILL
- fill_done  out  1  one-cycle pulse on completion or abort
- fill_stall_cnt  out  16  count of fill cycles lost to APB priority; saturating
- mem_wr  out  1  frame buffer write enable
- mem_data  out  DATA_W  frame buffer write data
- mem_waddr  out  ROW_W+COL_W  frame buffer write address {row,col}

Behaviour:
- Reset (async, presetn=0):
  - mem_wr, fill_busy, fill_done = 0; mem_data, mem_waddr = 0; fill_stall_cnt = 0.
  - FSM returns to IDLE; all latched fill parameters and counters = 0.
  - Assertion mid-fill kills the fill immediately; no fill_done is produced.
- All outputs are registered.
- APB path:
  - apb_wr=1 in cycle N gives mem_wr=1 in cycle N+1, with mem_data/mem_waddr equal to the cycle-N apb_data/apb_waddr.
  - Fixed 1-cycle latency under all conditions.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - fill_start=1 with rows≠0 and cols≠0:
    - latch colour, row0, col0, rows, cols;
    - row_ctr = 0, col_ctr = 0, fill_stall_cnt cleared;
    - go to FILL.
  - fill_start=1 with rows=0 or cols=0: go to DONE; no memory writes.
- FILL:
  - fill_busy=1.
  - Cycle with apb_wr=0:
    - issue a fill write next cycle: mem_waddr = {(row0+row_ctr) mod 2^ROW_W, (col0+col_ctr) mod 2^COL_W}, mem_data = colour;
    - advance col_ctr; at col_ctr = cols-1, wrap col_ctr to 0 and increment row_ctr.
  - Cycle with apb_wr=1: APB wins; counters hold; fill_stall_cnt +1, saturating at 16'hFFFF.
  - After the write for (rows-1, cols-1) is issued, go to DONE. Total fill writes = rows×cols exactly.
  - fill_abort=1: go to DONE without issuing that cycle's fill write. An APB write in the same cycle is still forwarded.
  - fill_start while in FILL is ignored.
- DONE:
  - fill_done=1 for exactly one cycle, fill_busy=0, then IDLE.
  - fill_start in DONE is ignored.
- Address wrap: row/col sums truncate modulo field width, e.g. col0=500, cols=20 → columns 500..511, then 0..7.
- fill_abort in IDLE or DONE has no effect.
- mem_wr is never asserted for two sources in the same cycle. The output register carries exactly one source per cycle.

Test Plan:
- APB only:
  - apb_wr pulses at addr 15'h0041 data 16'hF800, then addr 15'h7FFF data 16'h001F in consecutive cycles → mem_wr high two cycles, same addr/data, each 1 cycle later.
- Basic fill:
  - row0=2, rows=2, col0=10, cols=3, colour 16'h07E0, no APB traffic.
  - → 6 consecutive writes in order: {2,10},{2,11},{2,12},{3,10},{3,11},{3,12}.
  - → fill_done pulses one cycle after the last write; fill_busy low afterwards; fill_stall_cnt=0.
- Contention:
  - Same fill as above, with apb_wr asserted on fill cycles 2 and 3.
  - → APB writes appear unchanged at 1-cycle latency; the fill sequence is intact and complete (6 writes) but finishes 2 cycles later; fill_stall_cnt=2.
- Wrap and zero:
  - col0=510, cols=4, row0=63, rows=2 → columns 510,511,0,1 on rows 63, then 0.
  - fill_cols=0 → fill_done 2 cycles after start, zero mem_wr.
- Abort and restart:
  - fill_abort during a 64×512 fill at write #100 → exactly 100 fill writes, then fill_done; fill_start while busy ignored.
  - A new fill_start after DONE runs normally.
- Reset mid-fill:
  - presetn low during FILL → all outputs 0 immediately, no fill_done.
  - After release, an APB write is forwarded normally.
